// File: rtl/vfu_seq.sv
// ============================================================================
// Module   : vfu_seq
// Brief    : VFU result-stage command sequencer. It pops queued vector commands,
//            issues their operand beats and tags each beat through the datapath
//            latency so every result carries the operation of its command.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vfu_seq #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [1:0]       vfu_inst,
    output logic             vfu_en,
    output logic             res_valid,
    output logic             done,
    output logic             busy
);

    localparam int c_PTR_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_op, w_op_nxt;
    logic [CNT_W-1:0]   r_rem, w_rem_nxt;
    logic               r_pend, w_pend_nxt;

    logic [1:0]         r_fifo_op  [DEPTH];
    logic [CNT_W-1:0]   r_fifo_len [DEPTH];
    logic [c_PTR_W:0]   r_wr_ptr, r_rd_ptr;
    logic               w_empty, w_full, w_push, w_pop;
    logic [1:0]         w_head_op;
    logic [CNT_W-1:0]   w_head_len;

    logic               r_pv  [LAT];
    logic [1:0]         r_pop [LAT];
    logic               r_pl  [LAT];
    logic               w_s0_v, w_s0_l, w_pipe_any, w_last_beat;
    logic [1:0]         w_s0_op;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                        (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign cmd_ready  = !w_full;
    assign w_push     = cmd_valid && !w_full;
    assign w_head_op  = r_fifo_op[r_rd_ptr[c_PTR_W-1:0]];
    assign w_head_len = r_fifo_len[r_rd_ptr[c_PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr[c_PTR_W-1:0]]  <= cmd_op;
            r_fifo_len[r_wr_ptr[c_PTR_W-1:0]] <= cmd_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign w_last_beat = (r_rem <= CNT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_rem_nxt   = r_rem;
        w_pend_nxt  = 1'b0;
        w_pop       = 1'b0;
        w_s0_v      = 1'b0;
        w_s0_op     = 2'b00;
        w_s0_l      = 1'b0;
        op_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A zero-length command popped on a last beat owes its marker now.
                if (r_pend) begin
                    w_s0_l = 1'b1;
                end else if (!w_empty) begin
                    w_pop    = 1'b1;
                    w_op_nxt = w_head_op;
                    if (w_head_len == '0) begin
                        w_s0_l = 1'b1;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_rem_nxt   = w_head_len;
                    end
                end
            end
            S_ISSUE: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    w_s0_v    = 1'b1;
                    w_s0_op   = r_op;
                    w_s0_l    = w_last_beat;
                    w_rem_nxt = (r_rem == '0) ? '0 : r_rem - CNT_W'(1);
                    if (w_last_beat) begin
                        if (!w_empty) begin
                            w_pop    = 1'b1;
                            w_op_nxt = w_head_op;
                            if (w_head_len == '0) begin
                                w_state_nxt = S_IDLE;
                                w_pend_nxt  = 1'b1;
                            end else begin
                                w_rem_nxt = w_head_len;
                            end
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_rem   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_rem   <= w_rem_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // Tag pipe mirrors the arithmetic latency and never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                r_pv[i]  <= 1'b0;
                r_pop[i] <= 2'b00;
                r_pl[i]  <= 1'b0;
            end
        end else begin
            r_pv[0]  <= w_s0_v;
            r_pop[0] <= w_s0_op;
            r_pl[0]  <= w_s0_l;
            for (int i = 1; i < LAT; i++) begin
                r_pv[i]  <= r_pv[i-1];
                r_pop[i] <= r_pop[i-1];
                r_pl[i]  <= r_pl[i-1];
            end
        end
    end

    assign vfu_en   = r_pv[LAT-1];
    assign vfu_inst = r_pv[LAT-1] ? r_pop[LAT-1] : 2'b11;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            res_valid <= r_pv[LAT-1];
            done      <= r_pl[LAT-1];
        end
    end

    always_comb begin
        w_pipe_any = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            w_pipe_any = w_pipe_any | r_pv[i] | r_pl[i];
        end
    end

    assign busy = (r_state != S_IDLE) || r_pend || !w_empty || w_pipe_any ||
                  res_valid || done;

endmodule

`default_nettype wire

// File: tb/tb_vfu_seq.sv
// ============================================================================
// Module   : tb_vfu_seq
// Brief    : Scoreboard bench for vfu_seq: directed command scenarios with
//            per-result op/latency checks and per-command completion checks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vfu_seq;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_len = '0;
    logic             op_valid;
    logic             op_ready = 1'b1;
    logic [1:0]       vfu_inst;
    logic             vfu_en;
    logic             res_valid;
    logic             done;
    logic             busy;

    vfu_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .vfu_inst  (vfu_inst),
        .vfu_en    (vfu_en),
        .res_valid (res_valid),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [1:0] exp_op[$];
    int         exp_len[$];
    int         beat_q[$];
    int         done_q[$];
    int         first_opv = -1;
    int         res_cnt   = 0;
    logic       prev_en   = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 1'b0;
        end else begin
            if (op_valid && op_ready) begin
                if (first_opv < 0) first_opv = cyc;
                beat_q.push_back(cyc);
            end
            check("res_valid_follows_en", res_valid, prev_en);
            if (vfu_en) begin
                if (exp_op.size() == 0) check("unexpected_result", vfu_en, 0);
                else                    check("vfu_inst", vfu_inst, exp_op.pop_front());
                if (beat_q.size() > 0)  check("issue_latency", cyc - beat_q.pop_front(), LAT);
            end
            if (res_valid) res_cnt++;
            if (done) begin
                done_q.push_back(cyc);
                if (exp_len.size() == 0) check("unexpected_done", done, 0);
                else                     check("done_result_count", res_cnt, exp_len.pop_front());
                res_cnt = 0;
            end
            prev_en = vfu_en;
        end
    end

    task automatic send_cmd(input logic [1:0] op, input int len, output int acc);
        int n = 0;
        acc       = -1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len[CNT_W-1:0];
        while (acc < 0 && n < 200) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc;
                for (int i = 0; i < len; i++) exp_op.push_back(op);
                exp_len.push_back(len);
            end
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (acc < 0) check("cmd_accept_timeout", cmd_ready, 1);
    endtask

    task automatic drain(output int idle_cyc);
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        idle_cyc = cyc;
        check("drain_busy", busy, 0);
        check("sb_results_left", exp_op.size(), 0);
        check("sb_cmds_left", exp_len.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic begin_test();
        first_opv = -1;
        done_q.delete();
    endtask

    int t0, t1, ic, rise;
    int acc[6];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_op_valid", op_valid, 0);
        check("rst_vfu_en", vfu_en, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_vfu_inst", vfu_inst, 3);
        check("rst_cmd_ready", cmd_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single add command, len 3
        begin_test();
        send_cmd(2'b01, 3, t0);
        drain(ic);
        check("t1_first_op_valid", first_opv - t0, 2);
        check("t1_done_count", done_q.size(), 1);
        if (done_q.size() > 0) check("t1_done_cycle", done_q[0] - t0, 7);
        check("t1_idle_cycle", ic - t0, 8);

        // Back-to-back mult len 2, sub len 2
        begin_test();
        send_cmd(2'b00, 2, t0);
        send_cmd(2'b10, 2, t1);
        check("t2_accept_gap", t1 - t0, 1);
        drain(ic);
        check("t2_first_op_valid", first_opv - t0, 2);
        check("t2_done_count", done_q.size(), 2);
        if (done_q.size() > 1) begin
            check("t2_done0_cycle", done_q[0] - t0, 6);
            check("t2_done1_cycle", done_q[1] - t0, 8);
        end

        // Operand stall on cycles 3..5
        begin_test();
        send_cmd(2'b01, 3, t0);
        while (cyc < t0 + 3) begin @(posedge clk); #1; end
        op_ready = 1'b0;
        @(negedge clk);
        check("t3_op_valid_in_stall", op_valid, 1);
        while (cyc < t0 + 6) begin @(posedge clk); #1; end
        op_ready = 1'b1;
        drain(ic);
        check("t3_done_count", done_q.size(), 1);
        if (done_q.size() > 0) check("t3_done_cycle", done_q[0] - t0, 10);

        // FIFO full while operands are withheld
        begin_test();
        op_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_cmd(2'(k), 1, acc[k]);
            if (k > 0) check("t4_accept_gap", acc[k] - acc[k-1], 1);
        end
        @(negedge clk);
        check("t4_cmd_ready_full", cmd_ready, 0);
        fork
            send_cmd(2'b10, 1, acc[5]);
            begin
                repeat (3) @(posedge clk);
                #1;
                op_ready = 1'b1;
                rise = cyc;
            end
        join
        check("t4_sixth_accept", acc[5] - rise, 1);
        drain(ic);
        check("t4_done_count", done_q.size(), 6);

        // Zero-length command between two single-beat commands
        begin_test();
        send_cmd(2'b01, 1, t0);
        send_cmd(2'b11, 0, t1);
        send_cmd(2'b10, 1, t1);
        drain(ic);
        check("t5_done_count", done_q.size(), 3);

        // Reset during beat 4 of a len 8 mult
        begin_test();
        send_cmd(2'b00, 8, t0);
        while (cyc < t0 + 5) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_op_valid", op_valid, 0);
        check("t6_vfu_en", vfu_en, 0);
        check("t6_vfu_inst", vfu_inst, 3);
        check("t6_res_valid", res_valid, 0);
        check("t6_done", done, 0);
        check("t6_busy", busy, 0);
        check("t6_cmd_ready", cmd_ready, 1);
        exp_op.delete();
        exp_len.delete();
        beat_q.delete();
        res_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_q.delete();
        repeat (15) @(posedge clk);
        #1;
        check("t6_no_done_after_reset", done_q.size(), 0);
        check("t6_busy_after_reset", busy, 0);
        check("t6_cmd_ready_after_reset", cmd_ready, 1);
        begin_test();
        send_cmd(2'b01, 2, t0);
        drain(ic);
        check("t6_new_cmd_done_count", done_q.size(), 1);
        if (done_q.size() > 0) check("t6_new_cmd_done_cycle", done_q[0] - t0, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
